fejkon_identity_probe: RTL
==========================

Name: fejkon_identity_probe

Overview:
- Avalon-MM read master sitting directly upstream of the identity register slave.
- After reset (or on request) it reads both identity words: word 0 carries the ID/port counts, word 1 carries the git hash.
- It validates the magic, caches the fields and presents them as stable status outputs.
- Consumers are the front-panel/LED logic and the port-enable logic, which need the port counts without a CPU.

Parameters:
- ReadLatency, 1, fixed Avalon read latency of the slave in cycles (1..4); readdata is sampled exactly this many cycles after the read cycle.
- MaxRetries, 3, number of extra full probe attempts after a failed check before declaring failure (0..7).
- RetryGap, 16, idle cycles between a failed attempt and the next attempt (1..255).

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to re-probe; honoured only in DONE or FAIL.
- mm_address  out  1  word select: 0 = ID word, 1 = git hash.
- mm_read  out  1  read strobe, one cycle per word.
- mm_readdata  in  32  slave read data.
- fc_ports  out  4  cached ID word bits [27:24].
- eth_ports  out  4  cached ID word bits [31:28].
- git_hash  out  32  cached word 1.
- id_valid  out  1  cached fields valid and checked.
- id_error  out  1  all attempts failed.
- busy  out  1  probe in progress.

Behaviour:
- Reset values: all outputs 0, except busy=1. The FSM leaves reset in RD0, so the probe starts automatically on the first clock after reset deasserts.
- State RD0: mm_read=1, mm_address=0 for exactly one cycle, then go to W0. Latency counter loads ReadLatency.
- State W0: mm_read=0. Decrement the counter. When it expires, latch mm_readdata into a temporary ID register and go to RD1.
  - With ReadLatency=1, data is latched on the cycle after the read strobe.
- States RD1/W1: same as RD0/W0 with mm_address=1. On expiry, latch the temporary hash and go to CHECK.
- State CHECK (1 cycle): the attempt passes when both hold:
  - tmp_id[23:0] == 24'h010DE5;
  - tmp_id[27:24] != 0.
- CHECK pass: copy the temporaries to fc_ports/eth_ports/git_hash, set id_valid=1 and id_error=0, clear the retry count, then DONE.
- CHECK fail with retry count < MaxRetries: increment the count, load the gap counter with RetryGap, then GAP.
- CHECK fail with retry count == MaxRetries: set id_error=1 and id_valid=0, then FAIL.
- State GAP: count down, then go to RD0.
- busy = 1 in RD0/W0/RD1/W1/CHECK/GAP; 0 in DONE and FAIL.
- start in DONE/FAIL:
  - go to RD0 and clear the retry count;
  - id_valid is held, and the cached fields stay visible, until the new CHECK completes;
  - id_error is cleared on leaving FAIL.
- start in any busy state: ignored, no queuing.
- mm_address is held stable through the wait states, and mm_read is never asserted twice per word.
- Reset asserted mid-probe: everything returns to reset values immediately. Any outstanding slave response is ignored, because the counters are reset.
- Cached fields change only in CHECK-pass. eth_ports=0 is legal.

Optional Feature:
- Macro FEJKON_IDENTITY_PROBE_REFRESH_EN.
- When defined:
  - add parameter RefreshCycles (default 2**20);
  - a free-running counter in DONE triggers an automatic re-probe on expiry, as if start were pulsed;
  - add output id_changed: a sticky flag set when a passing CHECK yields fields that differ from the previously cached values while id_valid was 1;
  - id_changed is cleared only by reset.
- When undefined: no counter, no id_changed port; DONE is left only via start.

Decomposition:
- Package fejkon_identity_pkg holds:
  - IdMagic = 24'h010DE5;
  - word address constants AddrId=0 and AddrHash=1;
  - field bit positions (FC [27:24], ETH [31:28]);
  - state enum {RD0, W0, RD1, W1, CHECK, GAP, DONE, FAIL}.
- The identity slave model used by the bench imports the same package.
- No sub-module: the latency and gap counters share one down-counter inside the FSM.

Test Plan:
- Slave returns 32'h2201_0DE5 / 32'hDEADBEEF, ReadLatency=1 -> after reset, one read per address; id_valid=1, fc_ports=2, eth_ports=2, git_hash=DEADBEEF, busy=0 by cycle 6.
- Slave returns magic 24'h000000 always, MaxRetries=3, RetryGap=16 -> exactly 4 attempts (8 reads) spaced by 16-cycle gaps; id_error=1, id_valid=0, busy=0.
- Bad magic on attempt 1, good on attempt 2 -> id_valid=1, id_error=0; attempt 2 reads start 16 cycles after CHECK.
- ReadLatency=3 with a slave that drives valid data only on the 3rd cycle and garbage otherwise -> correct fields latched.
- start pulsed during W0 is ignored; start in DONE -> id_valid stays 1 throughout and fields update to new slave values; reset_n low during W1 -> all outputs 0 and busy=1 the same cycle, and the probe restarts on release.
- Refresh enabled, RefreshCycles=64, slave hash changes from 1 to 2 -> re-probe ~64 cycles after DONE; id_changed=1 and git_hash=2.

Source files
------------

// File: rtl/fejkon_identity_pkg.sv
// Shared constants and types for the identity probe and its slave model.
// Holds the magic value, word addresses, field positions and FSM states.
package fejkon_identity_pkg;

  localparam logic [23:0] IdMagic  = 24'h010DE5;
  localparam logic        AddrId   = 1'b0;
  localparam logic        AddrHash = 1'b1;
  localparam int          FcLsb    = 24;
  localparam int          EthLsb   = 28;
  localparam int          FieldW   = 4;

  typedef enum logic [2:0] {
    RD0, W0, RD1, W1, CHECK, GAP, DONE, FAIL
  } state_t;

  function automatic logic id_ok(input logic [31:0] w);
    return (w[23:0] == IdMagic) && (w[FcLsb +: FieldW] != '0);
  endfunction

endpackage

// File: rtl/fejkon_identity_probe.sv
// Avalon-MM read master that fetches, checks and caches the identity words.
// Ports: clk, reset_n, start, mm_address/mm_read/mm_readdata (Avalon-MM
// master), fc_ports, eth_ports, git_hash, id_valid, id_error, busy.
// Macro FEJKON_IDENTITY_PROBE_REFRESH_EN adds RefreshCycles and id_changed.
module fejkon_identity_probe
  import fejkon_identity_pkg::*;
#(
  parameter int ReadLatency = 1,
  parameter int MaxRetries  = 3,
  parameter int RetryGap    = 16
`ifdef FEJKON_IDENTITY_PROBE_REFRESH_EN
  , parameter int RefreshCycles = 2**20
`endif
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        mm_address,
  output logic        mm_read,
  input  logic [31:0] mm_readdata,
  output logic [3:0]  fc_ports,
  output logic [3:0]  eth_ports,
  output logic [31:0] git_hash,
  output logic        id_valid,
  output logic        id_error,
  output logic        busy
`ifdef FEJKON_IDENTITY_PROBE_REFRESH_EN
  , output logic      id_changed
`endif
);

  localparam logic [7:0] LatInit = 8'(ReadLatency);
  localparam logic [7:0] GapInit = 8'(RetryGap);
  localparam logic [2:0] MaxTry  = 3'(MaxRetries);

  state_t      state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic [2:0]  tries, tries_n;
  logic [31:0] tmp_id, tmp_hash;
  logic        ld_id, ld_hash;
  logic        pass, give_up;
  logic        kick;
  logic        idle;

  assign idle = (state == DONE) || (state == FAIL);
  assign busy = !idle;

  // Gated by reset so the bus is quiet while reset is held.
  assign mm_read    = reset_n && (state == RD0 || state == RD1);
  assign mm_address = reset_n && (state == RD1 || state == W1);

`ifdef FEJKON_IDENTITY_PROBE_REFRESH_EN
  localparam logic [31:0] RefLast = 32'(RefreshCycles - 1);
  logic [31:0] rcnt;
  logic        refresh_hit;

  assign refresh_hit = (state == DONE) && (rcnt == RefLast);
  assign kick = start || refresh_hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rcnt       <= '0;
      id_changed <= 1'b0;
    end else begin
      if (state != DONE || refresh_hit) rcnt <= '0;
      else                              rcnt <= rcnt + 32'd1;
      if (pass && id_valid &&
          ({tmp_id[31:24], tmp_hash} !=
           {eth_ports, fc_ports, git_hash}))
        id_changed <= 1'b1;
    end
  end
`else
  assign kick = start;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    tries_n = tries;
    ld_id   = 1'b0;
    ld_hash = 1'b0;
    pass    = 1'b0;
    give_up = 1'b0;
    unique case (state)
      RD0: begin
        state_n = W0;
        cnt_n   = LatInit;
      end
      W0: begin
        if (cnt == 8'd1) begin
          ld_id   = 1'b1;
          state_n = RD1;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      RD1: begin
        state_n = W1;
        cnt_n   = LatInit;
      end
      W1: begin
        if (cnt == 8'd1) begin
          ld_hash = 1'b1;
          state_n = CHECK;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      CHECK: begin
        if (id_ok(tmp_id)) begin
          pass    = 1'b1;
          tries_n = '0;
          state_n = DONE;
        end else if (tries < MaxTry) begin
          tries_n = tries + 3'd1;
          cnt_n   = GapInit;
          state_n = GAP;
        end else begin
          give_up = 1'b1;
          state_n = FAIL;
        end
      end
      GAP: begin
        if (cnt == 8'd1) state_n = RD0;
        else             cnt_n = cnt - 8'd1;
      end
      DONE, FAIL: begin
        if (kick) begin
          state_n = RD0;
          tries_n = '0;
        end
      end
      default: state_n = RD0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RD0;
      cnt       <= '0;
      tries     <= '0;
      tmp_id    <= '0;
      tmp_hash  <= '0;
      fc_ports  <= '0;
      eth_ports <= '0;
      git_hash  <= '0;
      id_valid  <= 1'b0;
      id_error  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      tries <= tries_n;
      if (ld_id)   tmp_id   <= mm_readdata;
      if (ld_hash) tmp_hash <= mm_readdata;
      if (pass) begin
        fc_ports  <= tmp_id[FcLsb +: FieldW];
        eth_ports <= tmp_id[EthLsb +: FieldW];
        git_hash  <= tmp_hash;
        id_valid  <= 1'b1;
        id_error  <= 1'b0;
      end else if (give_up) begin
        id_valid <= 1'b0;
        id_error <= 1'b1;
      end else if (state == FAIL && kick) begin
        id_error <= 1'b0;
      end
    end
  end

endmodule
